health_manager: RTL and testbench
=================================

HEALTH_MANAGER -- requirements
Module: health_manager

Interface
REQ-001 Parameter FULL_HEALTH, default 31, is the health value loaded at round start (1..31, fits 5 bits).
REQ-002 Parameter INVULN_CYCLES, default 4, is the number of cycles after an accepted hit during which further hits on that player are ignored (1..2^26-1).
REQ-003 Parameter REGEN_PERIOD, default 8, is the cycles between regen steps; it is used only under HEALTH_REGEN_EN.
REQ-004 clk  input  1  system clock; every register updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 round_start  input  1  single-cycle pulse that starts a new round.
REQ-007 hit_l  input  1  single-cycle pulse: the left player takes damage this cycle.
REQ-008 dmg_l  input  5  damage carried with hit_l.
REQ-009 hit_r  input  1  single-cycle pulse: the right player takes damage this cycle.
REQ-010 dmg_r  input  5  damage carried with hit_r.
REQ-011 curr_health_l  output  5  registered left health; it feeds the status bar.
REQ-012 curr_health_r  output  5  registered right health; it feeds the status bar.
REQ-013 ko  output  1  high while state is KO.
REQ-014 winner  output  2  00 none, 01 left won, 10 right won, 11 draw; registered.
REQ-015 fighting  output  1  high while state is FIGHT.

Function
REQ-016 The FSM has exactly three states: IDLE, FIGHT and KO.
- IDLE -> FIGHT on round_start.
- FIGHT -> KO on the edge where either health becomes 0.
- KO -> FIGHT on round_start.
- No other transitions exist.
REQ-017 A round_start in any state loads both healths with FULL_HEALTH, clears both invulnerability counters and winner, and enters FIGHT on the next edge; it overrides any hit in the same cycle.
REQ-018 A hit is accepted only when state is FIGHT, round_start is low, and that player's invulnerability counter is 0; all other hits are dropped silently.
REQ-019 An accepted hit in cycle N updates the health at edge N+1 to max(health - dmg, 0), computed 6 bits wide so that it never wraps.
REQ-020 A hit with dmg 0 is accepted, leaves health unchanged, and still starts invulnerability.
REQ-021 An accepted hit loads that player's counter with INVULN_CYCLES; the counter decrements once per cycle down to 0, and hits are accepted again on the cycle it reads 0.
REQ-022 Hits on both players in the same cycle are evaluated independently, and both are applied on the same edge.
REQ-023 On the edge where health becomes 0, state becomes KO in the same edge and winner is set:
- right health reached 0 only: 01;
- left health reached 0 only: 10;
- both reached 0: 11.
REQ-024 In KO, healths, counters and winner hold until round_start; hits have no effect.
REQ-025 Health never exceeds FULL_HEALTH and never goes below 0.

Reset
REQ-026 While rst_n is low:
- state is IDLE;
- curr_health_l and curr_health_r are FULL_HEALTH;
- counters are 0;
- winner is 00;
- ko and fighting are 0.
REQ-027 Reset asserted mid-round takes effect immediately without waiting for clk; after deassertion the block waits in IDLE for round_start.

Configuration
REQ-028 Macro HEALTH_REGEN_EN defined:
- in FIGHT, a per-player regen counter counts REGEN_PERIOD cycles;
- on expiry, health increments by 1 (saturating at FULL_HEALTH) if no hit is accepted on that player in that cycle;
- an accepted hit restarts that player's regen counter;
- health at 0 never regenerates.
REQ-029 Macro HEALTH_REGEN_EN undefined: no regen logic is compiled in, and health only decreases within a round.

Verification
REQ-030 Reset, then round_start -> next edge: fighting=1, both healths 31, winner=00.
REQ-031 hit_l dmg_l=10 at cycle N, hit_l dmg_l=5 at N+2 -> curr_health_l=21 at N+1 and stays 21 (second hit dropped, INVULN_CYCLES=4); hit_l dmg=5 at N+5 -> 16.
REQ-032 curr_health_r=3, hit_r dmg_r=20 -> curr_health_r=0, ko=1, winner=01, fighting=0 on the same edge; later hits change nothing.
REQ-033 Both healths 5, hit_l and hit_r with dmg 9 in the same cycle -> both 0, winner=11.
REQ-034 In KO, round_start together with hit_l dmg_l=31 -> healths 31/31, FIGHT, winner=00; the hit is ignored.
REQ-035 HEALTH_REGEN_EN defined, left health 20, no hits for 16 cycles -> 22; undefined -> 20.

Source files
------------

// File: rtl/health_manager.sv
// Two-player health tracker: round FSM, per-hit damage with invulnerability window, KO and winner.
// Optional macro HEALTH_REGEN_EN adds periodic +1 regeneration while fighting.
module health_manager #(
  parameter int unsigned FULL_HEALTH   = 31,
  parameter int unsigned INVULN_CYCLES = 4,
  parameter int unsigned REGEN_PERIOD  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       round_start,
  input  logic       hit_l,
  input  logic [4:0] dmg_l,
  input  logic       hit_r,
  input  logic [4:0] dmg_r,
  output logic [4:0] curr_health_l,
  output logic [4:0] curr_health_r,
  output logic       ko,
  output logic [1:0] winner,
  output logic       fighting
);

  localparam int unsigned InvW    = 26;
  localparam logic [4:0]  FullH   = 5'(FULL_HEALTH);
  localparam logic [InvW-1:0] InvLoad = InvW'(INVULN_CYCLES);

  if (FULL_HEALTH < 1 || FULL_HEALTH > 31 || INVULN_CYCLES < 1 || REGEN_PERIOD < 1)
  begin : gen_param_check
    $error("health_manager: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StFight, StKo} state_e;

  state_e          state_q, state_d;
  logic [4:0]      health_l_q, health_l_d, health_r_q, health_r_d;
  logic [InvW-1:0] inv_l_q, inv_l_d, inv_r_q, inv_r_d;
  logic [1:0]      winner_q, winner_d;
  logic            acc_l, acc_r;

`ifdef HEALTH_REGEN_EN
  localparam int unsigned RegenW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam logic [RegenW-1:0] RegenLast = RegenW'(REGEN_PERIOD - 1);
  logic [RegenW-1:0] regen_l_q, regen_l_d, regen_r_q, regen_r_d;
`endif

  // 6-bit difference so an oversized hit clamps at 0 instead of wrapping.
  function automatic logic [4:0] sat_sub(input logic [4:0] h, input logic [4:0] d);
    logic [5:0] diff;
    diff = {1'b0, h} - {1'b0, d};
    return diff[5] ? 5'd0 : diff[4:0];
  endfunction

  function automatic logic [InvW-1:0] inv_next(input logic acc, input logic [InvW-1:0] cnt);
    if (acc) return InvLoad;
    if (cnt != '0) return cnt - InvW'(1);
    return cnt;
  endfunction

  assign acc_l = (state_q == StFight) && !round_start && hit_l && (inv_l_q == '0);
  assign acc_r = (state_q == StFight) && !round_start && hit_r && (inv_r_q == '0);

  always_comb begin
    state_d    = state_q;
    health_l_d = health_l_q;
    health_r_d = health_r_q;
    inv_l_d    = inv_l_q;
    inv_r_d    = inv_r_q;
    winner_d   = winner_q;
`ifdef HEALTH_REGEN_EN
    regen_l_d  = regen_l_q;
    regen_r_d  = regen_r_q;
`endif
    if (round_start) begin
      state_d    = StFight;
      health_l_d = FullH;
      health_r_d = FullH;
      inv_l_d    = '0;
      inv_r_d    = '0;
      winner_d   = 2'b00;
`ifdef HEALTH_REGEN_EN
      regen_l_d  = '0;
      regen_r_d  = '0;
`endif
    end else if (state_q == StFight) begin
      inv_l_d = inv_next(acc_l, inv_l_q);
      inv_r_d = inv_next(acc_r, inv_r_q);
      if (acc_l) health_l_d = sat_sub(health_l_q, dmg_l);
      if (acc_r) health_r_d = sat_sub(health_r_q, dmg_r);
`ifdef HEALTH_REGEN_EN
      if (acc_l) begin
        regen_l_d = '0;
      end else if (regen_l_q == RegenLast) begin
        regen_l_d = '0;
        if (health_l_q != 5'd0 && health_l_q < FullH) health_l_d = health_l_q + 5'd1;
      end else begin
        regen_l_d = regen_l_q + RegenW'(1);
      end
      if (acc_r) begin
        regen_r_d = '0;
      end else if (regen_r_q == RegenLast) begin
        regen_r_d = '0;
        if (health_r_q != 5'd0 && health_r_q < FullH) health_r_d = health_r_q + 5'd1;
      end else begin
        regen_r_d = regen_r_q + RegenW'(1);
      end
`endif
      if (health_l_d == 5'd0 || health_r_d == 5'd0) begin
        state_d  = StKo;
        winner_d = {health_l_d == 5'd0, health_r_d == 5'd0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      health_l_q <= FullH;
      health_r_q <= FullH;
      inv_l_q    <= '0;
      inv_r_q    <= '0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      health_l_q <= health_l_d;
      health_r_q <= health_r_d;
      inv_l_q    <= inv_l_d;
      inv_r_q    <= inv_r_d;
      winner_q   <= winner_d;
    end
  end

`ifdef HEALTH_REGEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regen_l_q <= '0;
      regen_r_q <= '0;
    end else begin
      regen_l_q <= regen_l_d;
      regen_r_q <= regen_r_d;
    end
  end
`endif

  assign curr_health_l = health_l_q;
  assign curr_health_r = health_r_q;
  assign winner        = winner_q;
  assign ko            = (state_q == StKo);
  assign fighting      = (state_q == StFight);

endmodule

// File: tb/tb_health_manager.sv
// Bench for health_manager: directed vector table, async-reset sequence, randomized run against
// a timestamp-based reference model, and the regen scenario (HEALTH_REGEN_EN aware).
module tb_health_manager;

  localparam int FULL = 31;
  localparam int INV  = 4;
  localparam int PER  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       round_start = 1'b0;
  logic       hit_l = 1'b0;
  logic       hit_r = 1'b0;
  logic [4:0] dmg_l = 5'd0;
  logic [4:0] dmg_r = 5'd0;
  logic [4:0] curr_health_l, curr_health_r;
  logic       ko, fighting;
  logic [1:0] winner;

  health_manager #(
    .FULL_HEALTH  (FULL),
    .INVULN_CYCLES(INV),
    .REGEN_PERIOD (PER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .round_start  (round_start),
    .hit_l        (hit_l),
    .dmg_l        (dmg_l),
    .hit_r        (hit_r),
    .dmg_r        (dmg_r),
    .curr_health_l(curr_health_l),
    .curr_health_r(curr_health_r),
    .ko           (ko),
    .winner       (winner),
    .fighting     (fighting)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 fight, 2 ko; invulnerability and regen tracked as the
  // cycle index at which a player may next be hit / at which its regen period began.
  int m_phase, m_hl, m_hr, m_win;
  int m_okl, m_okr, m_rgl, m_rgr;

  task automatic model_reset();
    m_phase = 0; m_hl = FULL; m_hr = FULL; m_win = 0;
    m_okl = 0; m_okr = 0; m_rgl = 0; m_rgr = 0;
  endtask

  task automatic model_step(input bit rs, input bit hl, input int dl, input bit hr, input int dr);
    int nl, nr;
    bit al, ar;
    if (!rst_n) begin
      model_reset();
    end else if (rs) begin
      m_phase = 1; m_hl = FULL; m_hr = FULL; m_win = 0;
      m_okl = cyc + 1; m_okr = cyc + 1; m_rgl = cyc + 1; m_rgr = cyc + 1;
    end else if (m_phase == 1) begin
      al = hl && (cyc >= m_okl);
      ar = hr && (cyc >= m_okr);
      nl = m_hl;
      nr = m_hr;
      if (al) begin
        nl = (m_hl > dl) ? m_hl - dl : 0;
        m_okl = cyc + INV + 1;
        m_rgl = cyc + 1;
      end
`ifdef HEALTH_REGEN_EN
      else if ((cyc - m_rgl) % PER == PER - 1 && m_hl > 0 && m_hl < FULL) nl = m_hl + 1;
`endif
      if (ar) begin
        nr = (m_hr > dr) ? m_hr - dr : 0;
        m_okr = cyc + INV + 1;
        m_rgr = cyc + 1;
      end
`ifdef HEALTH_REGEN_EN
      else if ((cyc - m_rgr) % PER == PER - 1 && m_hr > 0 && m_hr < FULL) nr = m_hr + 1;
`endif
      m_hl = nl;
      m_hr = nr;
      if (nl == 0 || nr == 0) begin
        m_phase = 2;
        m_win = (nr == 0 ? 1 : 0) + (nl == 0 ? 2 : 0);
      end
    end
  endtask

  task automatic check(input string name, input int el, input int er, input int eko,
                       input int ewin, input int ef);
    vectors++;
    if ({curr_health_l, curr_health_r, ko, winner, fighting} !==
        {5'(el), 5'(er), 1'(eko), 2'(ewin), 1'(ef)}) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got hl=%0d hr=%0d ko=%0b win=%0d fight=%0b, expected hl=%0d hr=%0d ko=%0d win=%0d fight=%0d",
               name, cyc, curr_health_l, curr_health_r, ko, winner, fighting,
               el, er, eko, ewin, ef);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_hl, m_hr, (m_phase == 2) ? 1 : 0, m_win, (m_phase == 1) ? 1 : 0);
  endtask

  task automatic drive_cycle(input bit rs, input bit hl, input int dl, input bit hr, input int dr);
    @(negedge clk);
    round_start = rs; hit_l = hl; dmg_l = 5'(dl); hit_r = hr; dmg_r = 5'(dr);
    model_step(rs, hl, dl, hr, dr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit rs; bit hl; int dl; bit hr; int dr;
    int el; int er; int eko; int ewin; int ef;
  } vec_t;

  function automatic vec_t mk(bit rs, bit hl, int dl, bit hr, int dr,
                              int el, int er, int eko, int ewin, int ef);
    vec_t v;
    v.rs = rs; v.hl = hl; v.dl = dl; v.hr = hr; v.dr = dr;
    v.el = el; v.er = er; v.eko = eko; v.ewin = ewin; v.ef = ef;
    return v;
  endfunction

  vec_t tbl[30];

  initial begin
    tbl[0]  = mk(1, 0, 0,  0, 0,  31, 31, 0, 0, 1);  // round start
    tbl[1]  = mk(0, 1, 10, 0, 0,  21, 31, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0,  0, 0,  21, 31, 0, 0, 1);
    tbl[3]  = mk(0, 1, 5,  0, 0,  21, 31, 0, 0, 1);  // invulnerable: dropped
    tbl[4]  = mk(0, 0, 0,  0, 0,  21, 31, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0,  0, 0,  21, 31, 0, 0, 1);
    tbl[6]  = mk(0, 1, 5,  0, 0,  16, 31, 0, 0, 1);  // counter back at 0
    tbl[7]  = mk(0, 0, 0,  1, 28, 16, 3,  0, 0, 1);
    tbl[8]  = mk(0, 0, 0,  1, 20, 16, 3,  0, 0, 1);
    tbl[9]  = mk(0, 0, 0,  0, 0,  16, 3,  0, 0, 1);
    tbl[10] = mk(0, 0, 0,  0, 0,  16, 3,  0, 0, 1);
    tbl[11] = mk(0, 0, 0,  0, 0,  16, 3,  0, 0, 1);
    tbl[12] = mk(0, 0, 0,  1, 20, 16, 0,  1, 1, 0);  // KO, left wins
    tbl[13] = mk(0, 1, 31, 0, 0,  16, 0,  1, 1, 0);
    tbl[14] = mk(0, 0, 0,  1, 5,  16, 0,  1, 1, 0);
    tbl[15] = mk(1, 1, 31, 0, 0,  31, 31, 0, 0, 1);  // round start overrides hit
    tbl[16] = mk(0, 1, 26, 1, 26, 5,  5,  0, 0, 1);
    tbl[17] = mk(0, 1, 9,  1, 9,  5,  5,  0, 0, 1);
    tbl[18] = mk(0, 0, 0,  0, 0,  5,  5,  0, 0, 1);
    tbl[19] = mk(0, 0, 0,  0, 0,  5,  5,  0, 0, 1);
    tbl[20] = mk(0, 0, 0,  0, 0,  5,  5,  0, 0, 1);
    tbl[21] = mk(0, 1, 9,  1, 9,  0,  0,  1, 3, 0);  // draw
    tbl[22] = mk(1, 0, 0,  0, 0,  31, 31, 0, 0, 1);
    tbl[23] = mk(0, 1, 0,  0, 0,  31, 31, 0, 0, 1);  // zero damage still arms invuln
    tbl[24] = mk(0, 1, 7,  0, 0,  31, 31, 0, 0, 1);
    tbl[25] = mk(0, 0, 0,  0, 0,  31, 31, 0, 0, 1);
    tbl[26] = mk(0, 0, 0,  0, 0,  31, 31, 0, 0, 1);
    tbl[27] = mk(0, 0, 0,  0, 0,  31, 31, 0, 0, 1);
    tbl[28] = mk(0, 1, 7,  0, 0,  24, 31, 0, 0, 1);
    tbl[29] = mk(1, 0, 0,  0, 0,  31, 31, 0, 0, 1);

    model_reset();
    #2 rst_n = 1'b0;
    #1 check("reset", FULL, FULL, 0, 0, 0);
    drive_cycle(0, 1, 5, 1, 5);
    check("reset_hold", FULL, FULL, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 1, 5, 0, 0);
    check("idle_ignores_hit", FULL, FULL, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      drive_cycle(tbl[i].rs, tbl[i].hl, tbl[i].dl, tbl[i].hr, tbl[i].dr);
      check($sformatf("vec%0d", i), tbl[i].el, tbl[i].er, tbl[i].eko, tbl[i].ewin, tbl[i].ef);
    end

    // Async reset mid-round, asserted between clock edges.
    drive_cycle(0, 1, 10, 0, 0);
    check("pre_async_reset", 21, 31, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", FULL, FULL, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 1, 3, 1, 3);
    check("post_reset_idle", FULL, FULL, 0, 0, 0);

    // Randomized run against the model.
    drive_cycle(1, 0, 0, 0, 0);
    check_model("rand_start");
    for (int i = 0; i < 1500; i++) begin
      bit rs, hl, hr;
      int dl, dr;
      rs = ($urandom_range(0, 29) == 0);
      hl = ($urandom_range(0, 2) == 0);
      hr = ($urandom_range(0, 2) == 0);
      dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      drive_cycle(rs, hl, dl, hr, dr);
      check_model("rand");
    end

    // Regen scenario: left at 20, then 16 quiet cycles.
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 11, 0, 0);
    check("regen_base", 20, 31, 0, 0, 1);
    for (int i = 0; i < 16; i++) drive_cycle(0, 0, 0, 0, 0);
`ifdef HEALTH_REGEN_EN
    check("regen_16", 22, 31, 0, 0, 1);
`else
    check("regen_16", 20, 31, 0, 0, 1);
`endif
    check_model("regen_model");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
